// File: rtl/serial_adder_pkg.sv
// Shared types for the serial nibble adder.
// Nibble width and sequencer state encoding.
package serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/nibble_adder.sv
// Combinational 4-bit ripple-carry slice.
// Shared by every nibble of a serial add.
module nibble_adder
  import serial_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  logic [NIBBLE_W:0] c;

  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[NIBBLE_W];

endmodule

// File: rtl/serial_nibble_adder_ctrl.sv
// Multi-cycle WIDTH-bit adder on one shared nibble slice, LS nibble first.
// Define SUBTRACT_EN to add the sub port (a-b via ~b and carry-in 1).
module serial_nibble_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int CW  = $clog2(NIB) + 1;
  localparam int SW  = CW + 3;
  localparam logic [WIDTH-1:0] NMASK =
    WIDTH'({NIBBLE_W{1'b1}});

  state_t state, state_n;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
  logic             carry;
  logic             accept, step, inv;

  logic [SW-1:0]       sh;
  logic [NIBBLE_W-1:0] na, nb, ns;
  logic                nc;

`ifdef SUBTRACT_EN
  assign inv = sub;
`else
  assign inv = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CW'(NIB - 1)) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Bit offset of the nibble being processed this cycle
  assign sh = SW'(cnt) * SW'(NIBBLE_W);
  assign na = NIBBLE_W'(a_reg >> sh);
  assign nb = NIBBLE_W'(b_reg >> sh);

  nibble_adder u_slice (
    .a    (na),
    .b    (nb),
    .cin  (carry),
    .s    (ns),
    .cout (nc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
      cnt     <= '0;
      carry   <= 1'b0;
    end else if (accept) begin
      a_reg <= a;
      b_reg <= inv ? ~b : b;
      cnt   <= '0;
      carry <= inv;
    end else if (step) begin
      sum_reg <= (sum_reg & ~(NMASK << sh))
               | (WIDTH'(ns) << sh);
      carry   <= nc;
      cnt     <= cnt + 1'b1;
    end
  end

  assign sum  = sum_reg;
  assign cout = carry;

endmodule
